// File: rtl/am_tune_ctrl.sv
// am_tune_ctrl: turns five front-panel buttons into NCO phase-increment updates
// with debounce, press/auto-repeat, saturation and preset cycling.
module am_tune_ctrl #(
    parameter int unsigned         PHASE_W     = 40,
    parameter int unsigned         DEB_CYCLES  = 1000000,
    parameter int unsigned         RPT_DELAY   = 50000000,
    parameter int unsigned         RPT_PERIOD  = 10000000,
    parameter logic [PHASE_W-1:0]  FINE_STEP   = 40'h10c6f7,
    parameter logic [PHASE_W-1:0]  COARSE_STEP = 40'h346dc5d,
    parameter logic [PHASE_W-1:0]  PINC_MIN    = 40'h0a7c5ac47,
    parameter logic [PHASE_W-1:0]  PINC_MAX    = 40'h47ae147ae1,
    parameter logic [PHASE_W-1:0]  PRESET0     = 40'h2656abde3,
    parameter logic [PHASE_W-1:0]  PRESET1     = 40'h41fc8f323,
    parameter logic [PHASE_W-1:0]  PRESET2     = 40'h1e98dcdb3,
    parameter logic [PHASE_W-1:0]  PRESET3     = 40'h17f62b6ae
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_right,
    input  logic               btn_left,
    input  logic               btn_preset,
    output logic [PHASE_W-1:0] phase_inc,
    output logic               retune,
    output logic [1:0]         preset_idx,
    output logic [1:0]         state_dbg
);
    localparam int unsigned DCW  = $clog2(DEB_CYCLES + 1);
    localparam int unsigned TMAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STEP   = 2'd1,
        HOLD   = 2'd2,
        REPEAT = 2'd3
    } state_t;

    logic [4:0]             raw;
    logic [4:0]             sync1_q;
    logic [4:0]             sync2_q;
    logic [4:0]             deb_q;
    logic [4:0]             deb_d;
    logic [4:0][DCW-1:0]    cnt_q;
    logic [4:0][DCW-1:0]    cnt_d;
    logic                   prev_q;
    logic                   preset_edge;
    state_t                 state_q;
    state_t                 state_d;
    logic [2:0]             cmd;
    logic [2:0]             cmd_q;
    logic [2:0]             cmd_d;
    logic [TW-1:0]          timer_q;
    logic [TW-1:0]          timer_d;
    logic [PHASE_W-1:0]     phase_inc_q;
    logic [PHASE_W-1:0]     phase_inc_d;
    logic [1:0]             preset_idx_q;
    logic [1:0]             preset_idx_d;
    logic                   retune_q;
    logic                   up;
    logic                   dn;
    logic                   rt;
    logic                   lf;
    logic [PHASE_W-1:0]     step_mag;
    logic [PHASE_W:0]       sum;
    logic [PHASE_W-1:0]     stepped;
    logic [1:0]             nxt_idx;
    logic [PHASE_W-1:0]     nxt_preset;

    assign raw = {btn_preset, btn_left, btn_right, btn_down, btn_up};

    // A level change is accepted after DEB_CYCLES consecutive differing samples.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        for (int i = 0; i < 5; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DCW'(DEB_CYCLES - 1)) deb_d[i] = ~deb_q[i];
                else cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Opposing buttons cancel; a coarse command outranks a fine one.
    assign up  = deb_q[0] & ~deb_q[1];
    assign dn  = deb_q[1] & ~deb_q[0];
    assign rt  = deb_q[2] & ~deb_q[3];
    assign lf  = deb_q[3] & ~deb_q[2];
    assign cmd = up ? 3'b110 : dn ? 3'b111 : rt ? 3'b100 : lf ? 3'b101 : 3'b000;

    assign preset_edge = deb_q[4] & ~prev_q;
    assign nxt_idx     = preset_idx_q + 2'd1;
    assign nxt_preset  = (nxt_idx == 2'd0) ? PRESET0 :
                         (nxt_idx == 2'd1) ? PRESET1 :
                         (nxt_idx == 2'd2) ? PRESET2 : PRESET3;

    // One extra bit exposes a borrow or carry so the result saturates instead of wrapping.
    assign step_mag = cmd_q[1] ? COARSE_STEP : FINE_STEP;
    assign sum      = cmd_q[0] ? {1'b0, phase_inc_q} - {1'b0, step_mag}
                               : {1'b0, phase_inc_q} + {1'b0, step_mag};
    assign stepped  = (cmd_q[0] && sum[PHASE_W])  ? PINC_MIN :
                      (sum > {1'b0, PINC_MAX})     ? PINC_MAX :
                      (sum < {1'b0, PINC_MIN})     ? PINC_MIN : sum[PHASE_W-1:0];

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        timer_d      = timer_q;
        phase_inc_d  = phase_inc_q;
        preset_idx_d = preset_idx_q;
        case (state_q)
            IDLE: begin
                if (preset_edge) begin
                    preset_idx_d = nxt_idx;
                    phase_inc_d  = nxt_preset;
                end else if (cmd[2]) begin
                    state_d = STEP;
                    cmd_d   = cmd;
                end
            end
            STEP: begin
                phase_inc_d = stepped;
                timer_d     = TW'(RPT_DELAY);
                state_d     = HOLD;
            end
            default: begin
                if (!cmd[2]) begin
                    state_d = IDLE;
                end else if (cmd != cmd_q) begin
                    state_d = STEP;
                    cmd_d   = cmd;
                end else if (timer_q == TW'(1)) begin
                    phase_inc_d = stepped;
                    timer_d     = TW'(RPT_PERIOD);
                    state_d     = REPEAT;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            deb_q        <= '0;
            cnt_q        <= '0;
            prev_q       <= 1'b0;
            state_q      <= IDLE;
            cmd_q        <= '0;
            timer_q      <= '0;
            phase_inc_q  <= PRESET0;
            preset_idx_q <= 2'd0;
            retune_q     <= 1'b0;
        end else begin
            sync1_q      <= raw;
            sync2_q      <= sync1_q;
            deb_q        <= deb_d;
            cnt_q        <= cnt_d;
            prev_q       <= deb_q[4];
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            timer_q      <= timer_d;
            phase_inc_q  <= phase_inc_d;
            preset_idx_q <= preset_idx_d;
            retune_q     <= phase_inc_d != phase_inc_q;
        end
    end

    assign phase_inc  = phase_inc_q;
    assign retune     = retune_q;
    assign preset_idx = preset_idx_q;
    assign state_dbg  = state_q;
endmodule

// File: tb/tb_am_tune_ctrl.sv
// tb_am_tune_ctrl: directed and random button stimulus against a press-age
// schedule model of the tuning controller.
module tb_am_tune_ctrl;
    localparam int     DEB    = 4;
    localparam int     DLY    = 20;
    localparam int     PER    = 5;
    localparam longint P0     = 40'h2656abde3;
    localparam longint P1     = 40'h41fc8f323;
    localparam longint P2     = 40'h1e98dcdb3;
    localparam longint P3     = 40'h17f62b6ae;
    localparam longint FINE   = 40'h10c6f7;
    localparam longint COARSE = 40'h346dc5d;
    localparam longint PMIN   = 40'h0a7c5ac47;
    localparam longint PMAX   = 40'h47ae147ae1;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [4:0]  btn = '0;
    logic [39:0] phase_inc;
    logic        retune;
    logic [1:0]  preset_idx;
    logic [1:0]  state_dbg;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int rt_count;
    int rt_times[$];

    longint         presets [4] = '{P0, P1, P2, P3};
    logic [DEB+1:0] hist [5];
    logic [4:0]     m_deb;
    logic           m_prev;
    longint         m_pinc;
    longint         m_delta;
    int             m_age;
    int             m_idx;
    logic           m_rt;
    logic           m_force = 1'b0;
    longint         m_force_val;

    always #5 CLK = ~CLK;

    am_tune_ctrl #(
        .DEB_CYCLES (DEB),
        .RPT_DELAY  (DLY),
        .RPT_PERIOD (PER)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .btn_up     (btn[0]),
        .btn_down   (btn[1]),
        .btn_right  (btn[2]),
        .btn_left   (btn[3]),
        .btn_preset (btn[4]),
        .phase_inc  (phase_inc),
        .retune     (retune),
        .preset_idx (preset_idx),
        .state_dbg  (state_dbg)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        vectors++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint decode(input logic [4:0] d);
        if (d[0] && !d[1]) return COARSE;
        if (d[1] && !d[0]) return -COARSE;
        if (d[2] && !d[3]) return FINE;
        if (d[3] && !d[2]) return -FINE;
        return 0;
    endfunction

    function automatic int exp_state();
        if (m_delta == 0) return 0;
        if (m_age == 0) return 1;
        return (m_age < 1 + DLY) ? 2 : 3;
    endfunction

    task automatic set_pinc(input longint v);
        m_rt   = (v != m_pinc);
        m_pinc = v;
    endtask

    task automatic apply_step();
        longint v;
        v = m_pinc + m_delta;
        if (v > PMAX) v = PMAX;
        if (v < PMIN) v = PMIN;
        set_pinc(v);
    endtask

    task automatic model_reset();
        for (int b = 0; b < 5; b++) hist[b] = '0;
        m_deb   = '0;
        m_prev  = 1'b0;
        m_pinc  = P0;
        m_delta = 0;
        m_age   = 0;
        m_idx   = 0;
        m_rt    = 1'b0;
    endtask

    // Steps fall at press ages 1, 1+DLY, 1+DLY+k*PER after a command is latched.
    task automatic model_edge();
        longint c;
        logic   pe;
        c    = decode(m_deb);
        pe   = m_deb[4] & ~m_prev;
        m_rt = 1'b0;
        if (m_delta == 0) begin
            if (pe) begin
                m_idx = (m_idx + 1) % 4;
                set_pinc(presets[m_idx]);
            end else if (c != 0) begin
                m_delta = c;
                m_age   = 0;
            end
        end else begin
            m_age++;
            if (m_age == 1) apply_step();
            else if (c == 0) m_delta = 0;
            else if (c != m_delta) begin
                m_delta = c;
                m_age   = 0;
            end else if (m_age == 1 + DLY || (m_age > 1 + DLY && (m_age - 1 - DLY) % PER == 0))
                apply_step();
        end
        if (m_force) set_pinc(m_force_val);
        m_prev = m_deb[4];
        for (int b = 0; b < 5; b++) begin
            hist[b] = {hist[b][DEB:0], btn[b]};
            if (hist[b][DEB+1:2] == {DEB{~m_deb[b]}}) m_deb[b] = ~m_deb[b];
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pinc"},   phase_inc,  m_pinc);
        check({tag, ".retune"}, retune,     m_rt);
        check({tag, ".idx"},    preset_idx, m_idx);
        check({tag, ".state"},  state_dbg,  exp_state());
    endtask

    task automatic tick();
        model_edge();
        @(negedge CLK);
        cyc++;
        if (retune) begin
            rt_count++;
            rt_times.push_back(cyc);
        end
        check_all($sformatf("cyc%0d", cyc));
    endtask

    task automatic hold(input logic [4:0] v, input int n);
        btn = v;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic force_pinc(input logic [39:0] v);
        btn = '0;
        force dut.phase_inc_d = v;
        m_force     = 1'b1;
        m_force_val = v;
        tick();
        release dut.phase_inc_d;
        m_force = 1'b0;
    endtask

    initial begin
        int seq [5] = '{1, 2, 3, 0, 1};
        logic [4:0] v;
        model_reset();
        @(negedge CLK);
        check_all("reset");
        RST = 1'b0;

        rt_count = 0;
        hold(5'b00100, 15);
        hold(5'b00000, 30);
        check("tap.pinc", phase_inc, P0 + FINE);
        check("tap.retunes", rt_count, 1);

        hold(5'b00001, 40);
        do_reset();
        hold(5'b00001, 3);
        check("rst.nostep", phase_inc, P0);
        hold(5'b00000, 20);

        rt_count = 0;
        rt_times.delete();
        hold(5'b00001, 35);
        hold(5'b00000, 20);
        check("rpt.pinc", phase_inc, P0 + 4 * COARSE);
        check("rpt.retunes", rt_count, 4);
        if (rt_times.size() >= 4) begin
            check("rpt.gap1", rt_times[1] - rt_times[0], DLY);
            check("rpt.gap2", rt_times[2] - rt_times[1], PER);
            check("rpt.gap3", rt_times[3] - rt_times[2], PER);
        end

        force_pinc(40'(PMIN + 1));
        rt_count = 0;
        hold(5'b00010, 40);
        hold(5'b00000, 20);
        check("clamp_lo.pinc", phase_inc, PMIN);
        check("clamp_lo.retunes", rt_count, 1);

        force_pinc(40'(PMAX - 1));
        rt_count = 0;
        hold(5'b00001, 40);
        hold(5'b00000, 20);
        check("clamp_hi.pinc", phase_inc, PMAX);
        check("clamp_hi.retunes", rt_count, 1);

        rt_count = 0;
        hold(5'b00011, 40);
        hold(5'b00000, 10);
        repeat (6) begin
            hold(5'b01000, 2);
            hold(5'b00000, 3);
        end
        hold(5'b00000, 10);
        check("cancel.pinc", phase_inc, PMAX);
        check("cancel.retunes", rt_count, 0);

        do_reset();
        hold(5'b00000, 2);
        for (int k = 0; k < 5; k++) begin
            hold(5'b10000, 8);
            hold(5'b00000, 8);
            check($sformatf("preset%0d.idx", k), preset_idx, seq[k]);
        end
        check("preset.pinc", phase_inc, P1);
        hold(5'b00100, 40);
        check("preset.in_repeat", state_dbg, 3);
        hold(5'b10100, 10);
        hold(5'b00100, 5);
        hold(5'b00000, 20);
        check("preset.ignored", preset_idx, 1);

        for (int s = 0; s < 80; s++) begin
            v = 5'($urandom);
            if ($urandom_range(0, 3) == 0) v = '0;
            if ($urandom_range(0, 39) == 0) do_reset();
            hold(v, $urandom_range(1, 45));
        end
        hold(5'b00000, 20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
